// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP inference sequencer: command encodings,
// sequencer state encoding, default network dimensions and a width helper.
package mlp_pkg;

  localparam int unsigned MLP_N_IN  = 784;
  localparam int unsigned MLP_N_OUT = 10;
  localparam int unsigned MLP_N_HID = 64;

  typedef enum logic [1:0] {
    OP_LOAD_W   = 2'd0,
    OP_LOAD_LUT = 2'd1,
    OP_RUN      = 2'd2,
    OP_NOP      = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_W1,
    LOAD_W2,
    LOAD_LUT,
    RUN_CLR,
    RUN_SWEEP,
    RUN_DRAIN,
    RUN_CAP,
    RUN_DONE
  } seq_state_e;

  // Counter width for a 0..bound-1 range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/mlp_seq_delay.sv
// Valid-bit delay line between the hidden sweep and the layer-2 accumulator.
// pending is set while a valid is still queued behind the output stage.
module mlp_seq_delay
  import mlp_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic out_valid,
  output logic pending
);

  logic [PIPE_LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = in_valid;
    for (int unsigned b = 1; b < PIPE_LAT; b++) begin
      sr_d[b] = sr_q[b-1];
    end
    pending = in_valid;
    for (int unsigned b = 0; b + 1 < PIPE_LAT; b++) begin
      pending = pending | sr_q[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_valid = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/mlp_sequencer.sv
// Command sequencer for the two-layer MLP: weight/LUT loading and inference runs.
// Optional MLP_SEQ_PERF_EN adds the run_cycles saturating run-length counter.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned N_IN      = MLP_N_IN,
  parameter int unsigned N_OUT     = MLP_N_OUT,
  parameter int unsigned N_HID     = MLP_N_HID,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned LUT_DEPTH = 1024,
  parameter int unsigned PIPE_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [15:0]           s_data,
  output logic [1:0]            ram_en,
  output logic [N_IN+N_OUT-1:0] ram_we,
  output logic                  lut_we,
  output logic [ADDR_W-1:0]     addr,
  output logic [15:0]           wdata,
  output logic                  dp_reset,
  output logic                  l2_acc_en,
  output logic                  capture,
  output logic                  busy,
`ifdef MLP_SEQ_PERF_EN
  output logic [31:0]           run_cycles,
`endif
  output logic                  done
);

  localparam int unsigned WE_W = N_IN + N_OUT;
  localparam int unsigned HW   = cnt_w(N_HID);
  localparam int unsigned IW   = cnt_w(N_IN);
  localparam int unsigned OW   = cnt_w(N_OUT);
  localparam int unsigned KW   = cnt_w(LUT_DEPTH);
  localparam int unsigned XW   = cnt_w(WE_W);

  seq_state_e        state_q, state_d;
  logic [HW-1:0]     h_q, h_d;
  logic [IW-1:0]     i_q, i_d;
  logic [OW-1:0]     o_q, o_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WE_W-1:0]   ram_we_q, ram_we_d;
  logic              lut_we_q, lut_we_d;
  logic [1:0]        ld_en_q, ld_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [XW-1:0]     we_idx;
  logic              s_hs;
  logic              sweep;
  logic              pipe_pending;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s_ready   = (state_q == LOAD_W1) || (state_q == LOAD_W2) || (state_q == LOAD_LUT);
  assign sweep     = (state_q == RUN_SWEEP);
  assign dp_reset  = (state_q == RUN_CLR);
  assign capture   = (state_q == RUN_CAP);
  assign done      = (state_q == RUN_DONE);
  assign s_hs      = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    i_d      = i_q;
    o_d      = o_q;
    k_d      = k_q;
    ram_we_d = '0;
    lut_we_d = 1'b0;
    ld_en_d  = 2'b00;
    addr_d   = addr_q;
    wdata_d  = s_hs ? s_data : wdata_q;
    we_idx   = '0;
    case (state_q)
      IDLE: begin
        h_d = '0;
        i_d = '0;
        o_d = '0;
        k_d = '0;
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_LOAD_W:   state_d = LOAD_W1;
            OP_LOAD_LUT: state_d = LOAD_LUT;
            OP_RUN:      state_d = RUN_CLR;
            default:     state_d = IDLE;
          endcase
        end
      end
      LOAD_W1: if (s_hs) begin
        we_idx           = XW'(i_q);
        ram_we_d[we_idx] = 1'b1;
        ld_en_d          = 2'b01;
        addr_d           = ADDR_W'(h_q);
        if (i_q == IW'(N_IN - 1)) begin
          i_d = '0;
          if (h_q == HW'(N_HID - 1)) begin
            h_d     = '0;
            state_d = LOAD_W2;
          end else begin
            h_d = h_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      LOAD_W2: if (s_hs) begin
        we_idx           = XW'(N_IN) + XW'(o_q);
        ram_we_d[we_idx] = 1'b1;
        ld_en_d          = 2'b10;
        addr_d           = ADDR_W'(h_q);
        if (h_q == HW'(N_HID - 1)) begin
          h_d = '0;
          if (o_q == OW'(N_OUT - 1)) begin
            o_d     = '0;
            state_d = IDLE;
          end else begin
            o_d = o_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      LOAD_LUT: if (s_hs) begin
        lut_we_d = 1'b1;
        addr_d   = ADDR_W'(k_q);
        if (k_q == KW'(LUT_DEPTH - 1)) begin
          k_d     = '0;
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      RUN_CLR: state_d = RUN_SWEEP;
      RUN_SWEEP: begin
        if (h_q == HW'(N_HID - 1)) begin
          h_d     = '0;
          state_d = RUN_DRAIN;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      // Leave once nothing remains behind the delay-line output stage.
      RUN_DRAIN: if (!pipe_pending) state_d = RUN_CAP;
      RUN_CAP:   state_d = RUN_DONE;
      RUN_DONE:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      h_q      <= '0;
      i_q      <= '0;
      o_q      <= '0;
      k_q      <= '0;
      ram_we_q <= '0;
      lut_we_q <= 1'b0;
      ld_en_q  <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      i_q      <= i_d;
      o_q      <= o_d;
      k_q      <= k_d;
      ram_we_q <= ram_we_d;
      lut_we_q <= lut_we_d;
      ld_en_q  <= ld_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  mlp_seq_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sweep),
    .out_valid (l2_acc_en),
    .pending   (pipe_pending)
  );

  // Sweep drives the RAM read address directly; load writes use the registered path.
  assign ram_en = sweep ? 2'b11 : ld_en_q;
  assign addr   = sweep ? ADDR_W'(h_q) : addr_q;
  assign ram_we = ram_we_q;
  assign lut_we = lut_we_q;
  assign wdata  = wdata_q;

`ifdef MLP_SEQ_PERF_EN
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        in_run;

  always_comb begin
    in_run       = (state_q == RUN_CLR) || (state_q == RUN_SWEEP) || (state_q == RUN_DRAIN) ||
                   (state_q == RUN_CAP) || (state_q == RUN_DONE);
    run_cycles_d = run_cycles_q;
    if ((state_q == IDLE) && cmd_valid && (cmd_op == OP_RUN)) begin
      run_cycles_d = '0;
    end else if (in_run && (run_cycles_q != '1)) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_q <= '0;
    end else begin
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_mlp_sequencer.sv
// Scoreboard bench for mlp_sequencer: instance A (N_HID=2) for the full weight
// load, instance B (N_HID=64) for reset abort, LUT load, RUN timing and MLP_SEQ_PERF_EN.
module tb_mlp_sequencer;

  localparam int unsigned N_IN      = 784;
  localparam int unsigned N_OUT     = 10;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned LUT_DEPTH = 1024;
  localparam int unsigned PIPE_LAT  = 4;
  localparam int unsigned HID_A     = 2;
  localparam int unsigned HID_B     = 64;
  localparam int unsigned WE_W      = N_IN + N_OUT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid_a = 1'b0;
  logic        cmd_valid_b = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;

  logic              a_cmd_ready, a_s_ready, a_lut_we, a_dp_reset, a_l2_acc_en, a_capture, a_busy, a_done;
  logic [1:0]        a_ram_en;
  logic [WE_W-1:0]   a_ram_we;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_wdata;
  logic              b_cmd_ready, b_s_ready, b_lut_we, b_dp_reset, b_l2_acc_en, b_capture, b_busy, b_done;
  logic [1:0]        b_ram_en;
  logic [WE_W-1:0]   b_ram_we;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_wdata;
`ifdef MLP_SEQ_PERF_EN
  logic [31:0]       a_run_cycles, b_run_cycles;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_wr_a = 0;
  int          n_wr_b = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [63:0] obs_a, obs_b;

  always #5 clk = ~clk;

  mlp_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_HID(HID_A), .ADDR_W(ADDR_W),
    .LUT_DEPTH(LUT_DEPTH), .PIPE_LAT(PIPE_LAT)
  ) u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(a_cmd_ready), .cmd_op(cmd_op),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .ram_en(a_ram_en), .ram_we(a_ram_we),
    .lut_we(a_lut_we), .addr(a_addr), .wdata(a_wdata), .dp_reset(a_dp_reset), .l2_acc_en(a_l2_acc_en),
    .capture(a_capture), .busy(a_busy),
`ifdef MLP_SEQ_PERF_EN
    .run_cycles(a_run_cycles),
`endif
    .done(a_done)
  );

  mlp_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_HID(HID_B), .ADDR_W(ADDR_W),
    .LUT_DEPTH(LUT_DEPTH), .PIPE_LAT(PIPE_LAT)
  ) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(b_cmd_ready), .cmd_op(cmd_op),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .ram_en(b_ram_en), .ram_we(b_ram_we),
    .lut_we(b_lut_we), .addr(b_addr), .wdata(b_wdata), .dp_reset(b_dp_reset), .l2_acc_en(b_l2_acc_en),
    .capture(b_capture), .busy(b_busy),
`ifdef MLP_SEQ_PERF_EN
    .run_cycles(b_run_cycles),
`endif
    .done(b_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic lut, input logic any, input logic [1:0] en,
                                       input logic [15:0] idx, input logic [17:0] adr,
                                       input logic [15:0] d);
    return {2'b00, 8'h00, lut, any, en, idx, adr, d};
  endfunction

  function automatic logic [63:0] wr_obs(input logic [WE_W-1:0] we, input logic lut,
                                         input logic [1:0] en, input logic [ADDR_W-1:0] adr,
                                         input logic [15:0] d);
    logic [15:0] idx;
    int unsigned n;
    idx = '0;
    n   = 0;
    for (int unsigned b = 0; b < WE_W; b++) begin
      if (we[b]) begin
        idx = 16'(b);
        n++;
      end
    end
    if (n > 1) idx = 16'hFFFF;
    return pack(lut, n != 0, (n != 0) ? en : 2'b00, idx, adr, d);
  endfunction

  // Weight word n lands in layer 1 (input i, neuron h) then layer 2 (output o, neuron h).
  function automatic logic [63:0] w_exp(input int unsigned n, input int unsigned hid,
                                        input logic [15:0] d);
    if (n < hid * N_IN)
      return pack(1'b0, 1'b1, 2'b01, 16'(n % N_IN), 18'(n / N_IN), d);
    return pack(1'b0, 1'b1, 2'b10, 16'(N_IN + (n - hid * N_IN) / hid), 18'((n - hid * N_IN) % hid), d);
  endfunction

  always @(negedge clk) begin
    if ((a_ram_we != '0) || a_lut_we) begin
      obs_a = wr_obs(a_ram_we, a_lut_we, a_ram_en, a_addr, a_wdata);
      n_wr_a++;
      if (q_a.size() == 0) check("a_spurious_wr", obs_a, 64'd0);
      else check("a_wr", obs_a, q_a.pop_front());
    end
    if ((b_ram_we != '0) || b_lut_we) begin
      obs_b = wr_obs(b_ram_we, b_lut_we, b_ram_en, b_addr, b_wdata);
      n_wr_b++;
      if (q_b.size() == 0) check("b_spurious_wr", obs_b, 64'd0);
      else check("b_wr", obs_b, q_b.pop_front());
    end
  end

  task automatic issue(input bit to_b, input logic [1:0] op);
    @(negedge clk);
    cmd_op = op;
    if (to_b) cmd_valid_b = 1'b1;
    else cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
  endtask

  task automatic stream(input bit to_b, input int unsigned nwords, input bit toggle,
                        input bit is_lut, input int unsigned hid, input string tag);
    int unsigned sent;
    logic        rdy;
    logic [63:0] e;
    sent = 0;
    for (int unsigned cyc = 0; (sent < nwords) && (cyc < 3 * nwords + 10); cyc++) begin
      s_valid = !toggle || ((cyc % 2) == 0);
      s_data  = 16'($urandom);
      rdy     = to_b ? b_s_ready : a_s_ready;
      if (s_valid && rdy) begin
        e = is_lut ? pack(1'b1, 1'b0, 2'b00, 16'd0, 18'(sent), s_data) : w_exp(sent, hid, s_data);
        if (to_b) q_b.push_back(e);
        else q_a.push_back(e);
        sent++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    check(tag, 64'(sent), 64'(nwords));
  endtask

  task automatic do_run(input bit hold);
    logic [12:0] got, exp;
    @(negedge clk);
    cmd_op      = 2'd2;
    cmd_valid_b = 1'b1;
    for (int t = 1; t <= 73; t++) begin
      @(negedge clk);
      got = {b_dp_reset, b_l2_acc_en, b_capture, b_done, b_busy, b_cmd_ready, b_s_ready,
             b_ram_en, (b_ram_we != '0), b_lut_we, 2'b00};
      exp = {t == 1, (t >= 6) && (t <= 69), t == 70, t == 71,
             ((t >= 1) && (t <= 71)) || (hold && (t == 73)),
             !(((t >= 1) && (t <= 71)) || (hold && (t == 73))),
             hold && (t == 73),
             ((t >= 2) && (t <= 65)) ? 2'b11 : 2'b00, 1'b0, 1'b0, 2'b00};
      check($sformatf("run_ctrl_t%0d", t), 64'(got), 64'(exp));
      if ((t >= 2) && (t <= 65)) check($sformatf("run_addr_t%0d", t), 64'(b_addr), 64'(t - 2));
`ifdef MLP_SEQ_PERF_EN
      if (!hold && (t == 72)) check("run_cycles_after_done", 64'(b_run_cycles), 64'd71);
`endif
      if (t == 1) begin
        if (hold) cmd_op = 2'd0;
        else cmd_valid_b = 1'b0;
      end
    end
    cmd_valid_b = 1'b0;
  endtask

  initial begin
    int wr_before;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a", {a_ram_we != '0, a_lut_we, a_addr, a_wdata, a_busy, a_cmd_ready, a_done, a_capture,
                    a_dp_reset, a_l2_acc_en, a_ram_en, a_s_ready},
                   {1'b0, 1'b0, 18'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    check("rst_b", {b_ram_we != '0, b_lut_we, b_addr, b_wdata, b_busy, b_cmd_ready, b_done, b_capture,
                    b_dp_reset, b_l2_acc_en, b_ram_en, b_s_ready},
                   {1'b0, 1'b0, 18'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
`ifdef MLP_SEQ_PERF_EN
    check("rst_run_cycles", 64'(b_run_cycles), 64'd0);
`endif

    // Abort a weight load at h=2, i=100.
    issue(1'b1, 2'd0);
    stream(1'b1, 2 * N_IN + 100, 1'b0, 1'b0, HID_B, "b_partial_sent");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {b_busy, b_cmd_ready, b_s_ready}, {1'b0, 1'b1, 1'b0});
    check("abort_ram_we", 64'(b_ram_we != '0), 64'd0);
    check("abort_q_b", 64'(q_b.size()), 64'd0);

    issue(1'b1, 2'd3);
    check("nop_idle", {b_busy, b_cmd_ready}, {1'b0, 1'b1});

    issue(1'b0, 2'd0);
    stream(1'b0, HID_A * (N_IN + N_OUT), 1'b0, 1'b0, HID_A, "a_w_sent");
    repeat (2) @(negedge clk);
    check("a_w_writes", 64'(n_wr_a), 64'(HID_A * (N_IN + N_OUT)));
    check("a_w_q_empty", 64'(q_a.size()), 64'd0);
    check("a_w_idle", {a_busy, a_cmd_ready}, {1'b0, 1'b1});

    do_run(1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_run(1'b0);

    wr_before = n_wr_b;
    issue(1'b1, 2'd1);
    stream(1'b1, LUT_DEPTH, 1'b1, 1'b1, HID_B, "b_lut_sent");
    repeat (2) @(negedge clk);
    check("b_lut_writes", 64'(n_wr_b - wr_before), 64'(LUT_DEPTH));
    check("b_lut_q_empty", 64'(q_b.size()), 64'd0);
    check("b_lut_idle", {b_busy, b_cmd_ready}, {1'b0, 1'b1});
`ifdef MLP_SEQ_PERF_EN
    check("run_cycles_after_lut", 64'(b_run_cycles), 64'd71);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mlp_sequencer.md
Name: mlp_sequencer

Overview:
Control block for the two-layer MLP inference datapath: 784 inputs, N_HID hidden neurons, 10 outputs.
- Accepts host commands over a valid/ready interface.
- Streams 16-bit weight words into the per-input and per-output weight RAMs, using one-hot write enables plus a shared address.
- Streams words into the activation lookup tables.
- Sequences one inference pass: datapath clear, hidden-neuron sweep, layer-2 accumulate, output capture, done.
- Sits between the host/testbench and the network top; it is the sole driver of the top's en, we, active_we, addr, wdata and datapath reset.

Parameters:
N_IN, 784, layer-1 fan-in; one weight RAM per input.
N_OUT, 10, output neurons; one weight RAM per output.
N_HID, 64, hidden neurons; RAM depth used, 1..2^ADDR_W.
ADDR_W, 18, weight RAM address width.
LUT_DEPTH, 1024, activation LUT entries loaded per LOAD_LUT command.
PIPE_LAT, 4, cycles from RAM address issue to valid layer-1 activation at layer-2 input.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0=LOAD_W, 1=LOAD_LUT, 2=RUN, 3=reserved (accepted, no-op)
s_valid  in  1  data word offered
s_ready  out  1  high in LOAD_W/LOAD_LUT
s_data  in  16  weight or LUT word
ram_en  out  2  bit0 layer-1 RAM enable, bit1 layer-2 RAM enable
ram_we  out  N_IN+N_OUT  one-hot write enable; [N_IN-1:0] layer 1, upper N_OUT layer 2
lut_we  out  1  activation LUT write strobe
addr  out  ADDR_W  shared RAM/LUT address
wdata  out  16  registered copy of s_data
dp_reset  out  1  datapath accumulator clear
l2_acc_en  out  1  layer-2 accumulate enable
capture  out  1  one-cycle output-register load
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of RUN

Behaviour:
Reset values: state=IDLE; all strobes 0, addr 0, wdata 0, busy 0, cmd_ready 1.
Reset in any state returns to IDLE on the next edge and aborts the operation. No partial-write rollback.

FSM states: IDLE, LOAD_W1, LOAD_W2, LOAD_LUT, RUN_CLR, RUN_SWEEP, RUN_DRAIN, RUN_CAP, RUN_DONE.
- IDLE: a command is accepted on cmd_valid && cmd_ready.
  - op0 -> LOAD_W1
  - op1 -> LOAD_LUT
  - op2 -> RUN_CLR
  - op3 -> stay in IDLE
- Data handshake: a word is transferred only on s_valid && s_ready. A stall (s_valid low) holds all counters, and ram_we/lut_we are 0 that cycle.
- Write outputs are registered: ram_we/lut_we, addr and wdata appear 1 cycle after the handshake.
- LOAD_W1: nested counters h (0..N_HID-1, outer) and i (0..N_IN-1, inner). Each word produces ram_we=1<<i, addr=h, ram_en=2'b01. After h=N_HID-1, i=N_IN-1 -> LOAD_W2.
- LOAD_W2: counters o (outer, 0..N_OUT-1) and h (inner). Each word produces ram_we=1<<(N_IN+o), addr=h, ram_en=2'b10. After the last word -> IDLE.
  - Total LOAD_W words = N_HID*(N_IN+N_OUT).
- LOAD_LUT: k = 0..LUT_DEPTH-1. Each word produces lut_we=1, addr=k. After the last word -> IDLE.
- RUN_CLR: dp_reset=1 for exactly 1 cycle -> RUN_SWEEP.
- RUN_SWEEP: N_HID cycles with ram_en=2'b11 and addr=h, h=0..N_HID-1 -> RUN_DRAIN.
- l2_acc_en is the sweep-valid bit delayed by PIPE_LAT through a shift register. It is high for exactly N_HID cycles, starting PIPE_LAT cycles after the first sweep cycle.
- RUN_DRAIN: waits until the delay line empties (PIPE_LAT cycles) -> RUN_CAP.
- RUN_CAP: capture=1 for 1 cycle -> RUN_DONE.
- RUN_DONE: done=1 for 1 cycle -> IDLE.
- RUN latency from command acceptance to done = 1+N_HID+PIPE_LAT+2 cycles.
- Never more than one ram_we bit high. ram_we and lut_we are never high together.
- Counter widths are $clog2 of the bound (minimum 1). No wrap occurs mid-command because terminal counts always end the state.
- No data words are consumed in RUN. s_ready=0 outside the load states.

Optional Feature:
Macro MLP_SEQ_PERF_EN.
- Defined: adds output run_cycles[31:0], a saturating cycle counter. It clears on RUN acceptance, increments every busy cycle, freezes at done and holds until the next RUN. Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mlp_pkg holds the cmd_op encodings (OP_LOAD_W, OP_LOAD_LUT, OP_RUN, OP_NOP), the FSM state enum, and the default N_IN/N_OUT/N_HID constants.
- One natural sub-module, mlp_seq_delay: a PIPE_LAT-deep valid shift register with an any-valid flag, used for l2_acc_en and the drain condition.

Test Plan:
- Reset mid-LOAD_W1 at h=2, i=100 -> next cycle state IDLE, ram_we=0, cmd_ready=1.
- N_HID=2, LOAD_W with continuous s_valid -> 1588 writes. Word 0 gives ram_we[0], addr 0. Word 784 gives ram_we[0], addr 1. Word 1568 gives ram_we[784], addr 0. Last word gives ram_we[793], addr 1.
- LOAD_LUT with s_valid toggling every other cycle -> exactly LUT_DEPTH lut_we pulses with addr 0..1023 in order, no writes on stall cycles.
- RUN with N_HID=64, PIPE_LAT=4 -> dp_reset at cycle 1, l2_acc_en high cycles 6..69, capture at 70, done at 71, busy low at 72.
- cmd_valid held during RUN with op=LOAD_W -> not accepted until after done; ram_we stays 0 throughout RUN.
- MLP_SEQ_PERF_EN defined, RUN with N_HID=64 -> run_cycles = 71 after done, unchanged by a subsequent LOAD_LUT.
